// File: rtl/picomips_demo_pkg.sv
// Shared types and helpers for the picoMIPS DE0 run controller.
package picomips_demo_pkg;

   typedef enum logic [1:0] {
      HALT = 2'b00,
      SLOW = 2'b01,
      FAST = 2'b10,
      STEP = 2'b11
   } run_mode_t;

   localparam int EN_COUNT_W = 16;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/picomips_demo_ctrl_sync_debounce.sv
// One-bit 2-flop synchroniser followed by a debouncer.
// Clean output follows the raw input 2+DB_CYCLES cycles after it settles.
module sync_debounce
   import picomips_demo_pkg::*;
#(
   parameter int DB_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic raw_i,
   output logic clean_o
);

   localparam int CW = cnt_width(DB_CYCLES);

   logic          sync1_q, sync2_q;
   logic          clean_q, clean_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter runs only while input disagrees; flips on the DB_CYCLES-th such cycle.
   always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      if (sync2_q != clean_q) begin
         if (cnt_q == CW'(DB_CYCLES - 1))
            clean_d = sync2_q;
         else
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clean_o = clean_q;

endmodule

// File: rtl/picomips_demo_ctrl.sv
// Run controller between DE0 I/O and the cpu: debounced inputs, clock-enable modes, LED and enable count.
// Optional PICOMIPS_HEARTBEAT_EN: heartbeat toggles per tick and drives led_out[N_LED-1].
module picomips_demo_ctrl
   import picomips_demo_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 10,
   parameter int N_SW      = 10,
   parameter int N_LED     = 8,
   parameter int DB_CYCLES = 250000
) (
   input  logic                  fastclk,
   input  logic                  n_reset,
   input  logic [N_SW-1:0]       sw_raw,
   input  logic [1:0]            mode_raw,
   input  logic                  step_raw,
   input  logic [N_LED-1:0]      cpu_led,
   output logic [N_SW-1:0]       sw_clean,
   output logic                  cpu_en,
   output logic [N_LED-1:0]      led_out,
   output logic [EN_COUNT_W-1:0] en_count,
   output logic                  heartbeat
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int TW  = cnt_width(DIV);
   localparam int NB  = N_SW + 3;

   logic [NB-1:0] raw_vec, db_vec;

   assign raw_vec = {step_raw, mode_raw, sw_raw};

   for (genvar g = 0; g < NB; g++) begin : g_db
      sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk_i   (fastclk),
         .rst_n_i (n_reset),
         .raw_i   (raw_vec[g]),
         .clean_o (db_vec[g])
      );
   end

   run_mode_t               mode_q, mode_d;
   logic                    step_db, step_prev_q, step_rise;
   logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
   logic                    tick;
   logic                    cpu_en_q, cpu_en_d;
   logic [N_LED-1:0]        led_q, led_d;
   logic [EN_COUNT_W-1:0]   en_count_q, en_count_d;
   logic                    hb_q, hb_d;

   assign sw_clean  = db_vec[N_SW-1:0];
   assign mode_d    = run_mode_t'(db_vec[N_SW+1:N_SW]);
   assign step_db   = db_vec[N_SW+2];
   assign step_rise = step_db & ~step_prev_q;
   assign tick      = (tick_cnt_q == TW'(DIV - 1));

   always_comb begin
      // Restart the tick phase when slow mode is entered so the first pulse is a full period away.
      if (mode_d == SLOW && mode_q != SLOW)
         tick_cnt_d = '0;
      else if (tick)
         tick_cnt_d = '0;
      else
         tick_cnt_d = tick_cnt_q + 1'b1;

      case (mode_q)
         SLOW:    cpu_en_d = tick;
         FAST:    cpu_en_d = 1'b1;
         STEP:    cpu_en_d = step_rise && (mode_d == STEP);
         default: cpu_en_d = 1'b0;
      endcase

      en_count_d = cpu_en_q ? en_count_q + 1'b1 : en_count_q;
      led_d      = cpu_en_q ? cpu_led : led_q;
`ifdef PICOMIPS_HEARTBEAT_EN
      hb_d              = hb_q ^ tick;
      led_d[N_LED-1]    = hb_d;
`else
      hb_d              = 1'b0;
`endif
   end

   always_ff @(posedge fastclk) begin
      if (!n_reset) begin
         mode_q      <= HALT;
         step_prev_q <= 1'b0;
         tick_cnt_q  <= '0;
         cpu_en_q    <= 1'b0;
         led_q       <= '0;
         en_count_q  <= '0;
         hb_q        <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         step_prev_q <= step_db;
         tick_cnt_q  <= tick_cnt_d;
         cpu_en_q    <= cpu_en_d;
         led_q       <= led_d;
         en_count_q  <= en_count_d;
         hb_q        <= hb_d;
      end
   end

   assign cpu_en    = cpu_en_q;
   assign led_out   = led_q;
   assign en_count  = en_count_q;
   assign heartbeat = hb_q;

endmodule

// File: tb/tb_picomips_demo_ctrl.sv
// Directed bench for picomips_demo_ctrl with a queue of expected results.
module tb_picomips_demo_ctrl;

   localparam int N_SW  = 10;
   localparam int N_LED = 8;

`ifdef PICOMIPS_HEARTBEAT_EN
   localparam logic [7:0] LED_MASK = 8'h7F;
   localparam int         HB_TOG   = 4;
`else
   localparam logic [7:0] LED_MASK = 8'hFF;
   localparam int         HB_TOG   = 0;
`endif

   logic              fastclk = 1'b0;
   logic              n_reset = 1'b0;
   logic [N_SW-1:0]   sw_raw  = '0;
   logic [1:0]        mode_raw = 2'b00;
   logic              step_raw = 1'b0;
   logic [N_LED-1:0]  cpu_led = '0;
   logic [N_SW-1:0]   sw_clean;
   logic              cpu_en;
   logic [N_LED-1:0]  led_out;
   logic [15:0]       en_count;
   logic              heartbeat;

   picomips_demo_ctrl #(
      .CLK_HZ(100), .TICK_HZ(10), .N_SW(N_SW), .N_LED(N_LED), .DB_CYCLES(4)
   ) dut (
      .fastclk(fastclk), .n_reset(n_reset), .sw_raw(sw_raw), .mode_raw(mode_raw),
      .step_raw(step_raw), .cpu_led(cpu_led), .sw_clean(sw_clean), .cpu_en(cpu_en),
      .led_out(led_out), .en_count(en_count), .heartbeat(heartbeat)
   );

   always #5 fastclk = ~fastclk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge fastclk);
         @(negedge fastclk);
      end
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      cyc(2);
      n_reset = 1'b1;
   endtask

   task automatic wait_en(input string tag, input int max);
      int k = 0;
      while (cpu_en !== 1'b1 && k < max) begin
         cyc(1);
         k++;
      end
      push(tag, 1);
      check(cpu_en);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi[$];
      int pulses;
      int k;
      int tog;
      logic hb_prev;

      @(negedge fastclk);
      do_reset();

      // Reset state
      push("rst_sw_clean", 0);  check(sw_clean);
      push("rst_cpu_en", 0);    check(cpu_en);
      push("rst_led_out", 0);   check(led_out);
      push("rst_en_count", 0);  check(en_count);
      push("rst_heartbeat", 0); check(heartbeat);

      // Debounce: 3-cycle glitch ignored, then a held rise appears after exactly 6 cycles
      sw_raw[0] = 1'b1;
      cyc(3);
      sw_raw[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push("db_glitch", 0);
         cyc(1);
         check(sw_clean[0]);
      end
      sw_raw[0] = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         push("db_rise", (n == 6) ? 1 : 0);
         cyc(1);
         check(sw_clean[0]);
      end

      // SLOW: single-cycle pulses 10 apart
      sw_raw = '0;
      do_reset();
      mode_raw = 2'b01;
      for (int c = 0; c < 60 && hi.size() < 3; c++) begin
         cyc(1);
         if (cpu_en === 1'b1) hi.push_back(c);
      end
      push("slow_pulses", 3);
      check(hi.size());
      if (hi.size() >= 3) begin
         push("slow_gap1", 10); check(hi[1] - hi[0]);
         push("slow_gap2", 10); check(hi[2] - hi[1]);
      end
      cyc(1);
      push("slow_pulse_width", 0); check(cpu_en);
      push("slow_en_count", 3);    check(en_count);

      // STEP: held press gives one pulse, second press another, bounce none
      do_reset();
      mode_raw = 2'b11;
      cyc(10);
      pulses = 0;
      step_raw = 1'b1;
      for (int i = 0; i < 50; i++) begin cyc(1); pulses += int'(cpu_en); end
      step_raw = 1'b0;
      for (int i = 0; i < 20; i++) begin cyc(1); pulses += int'(cpu_en); end
      step_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin cyc(1); pulses += int'(cpu_en); end
      step_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin cyc(1); pulses += int'(cpu_en); end
      push("step_pulses", 2);    check(pulses);
      push("step_en_count", 2);  check(en_count);
      pulses = 0;
      step_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin cyc(1); pulses += int'(cpu_en); end
      step_raw = 1'b0;
      for (int i = 0; i < 15; i++) begin cyc(1); pulses += int'(cpu_en); end
      push("step_bounce", 0);    check(pulses);
      // A press made while halted is not replayed on re-entering STEP
      mode_raw = 2'b00;
      cyc(10);
      step_raw = 1'b1;
      cyc(10);
      step_raw = 1'b0;
      cyc(10);
      mode_raw = 2'b11;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin cyc(1); pulses += int'(cpu_en); end
      push("step_not_queued", 0); check(pulses);
      push("step_en_count2", 2);  check(en_count);

      // FAST for 20 enable cycles, then HALT freezes the LEDs
      do_reset();
      cpu_led  = 8'hA5;
      mode_raw = 2'b10;
      wait_en("fast_start", 40);
      push("fast_count0", 0);  check(en_count);
      cyc(20);
      push("fast_en_count", 20);         check(en_count);
      push("fast_still_en", 1);          check(cpu_en);
      push("fast_led", 8'hA5 & LED_MASK); check(led_out & LED_MASK);
      mode_raw = 2'b00;
      k = 20;
      for (int t = 0; t < 30 && cpu_en === 1'b1; t++) begin
         k++;
         cyc(1);
      end
      push("halt_en", 0); check(cpu_en);
      cpu_led = 8'h3C;
      cyc(10);
      push("halt_led", 8'hA5 & LED_MASK); check(led_out & LED_MASK);
      push("halt_en_held", 0);            check(cpu_en);
      push("halt_en_count", k);           check(en_count);

      // Heartbeat over 40 halted cycles
      do_reset();
      mode_raw = 2'b00;
      tog = 0;
      hb_prev = heartbeat;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (heartbeat !== hb_prev) tog++;
         hb_prev = heartbeat;
      end
      push("hb_toggles", HB_TOG); check(tog);
`ifdef PICOMIPS_HEARTBEAT_EN
      cyc(5);
      push("hb_led_msb", heartbeat); check(led_out[7]);
`else
      push("hb_led_zero", 0); check(led_out);
`endif

      // en_count wrap, then reset mid-run
      sw_raw = 10'h3FF;
      do_reset();
      cpu_led  = 8'h5A;
      mode_raw = 2'b10;
      wait_en("wrap_start", 40);
      push("wrap_sw_clean", 10'h3FF); check(sw_clean);
      cyc(65535);
      push("wrap_ffff", 16'hFFFF); check(en_count);
      cyc(1);
      push("wrap_zero", 0);        check(en_count);
      n_reset = 1'b0;
      cyc(1);
      push("mid_rst_sw_clean", 0);  check(sw_clean);
      push("mid_rst_cpu_en", 0);    check(cpu_en);
      push("mid_rst_led_out", 0);   check(led_out);
      push("mid_rst_en_count", 0);  check(en_count);
      push("mid_rst_heartbeat", 0); check(heartbeat);
      n_reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin cyc(1); pulses += int'(cpu_en); end
      push("post_rst_halt", 0); check(pulses);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/picomips_demo_ctrl.md
Name: picomips_demo_ctrl

Overview:
- Parametrised board-level run controller placed between the DE0 I/O (fastclk, switches, LEDs) and the cpu core.
- Replaces the fixed slow-clock counter with a clock-enable generator; all logic stays in the fastclk domain with no derived clocks.
- Synchronises and debounces switches and a step button, and selects one of four run modes: halt, slow, full-speed, single-step.
- Registers cpu LED output and counts executed enable cycles.

Parameters:
- CLK_HZ, 50000000, fastclk frequency in Hz.
- TICK_HZ, 10, slow-mode enable rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be ≥2.
- N_SW, 10, number of data switches.
- N_LED, 8, LED width.
- DB_CYCLES, 250000, consecutive stable cycles required for debounce acceptance; must be ≥1.

Ports:
- fastclk  in  1  system clock, sole clock.
- n_reset  in  1  synchronous, active-low reset.
- sw_raw  in  N_SW  raw switches.
- mode_raw  in  2  raw run-mode switches.
- step_raw  in  1  raw step push-button, high = pressed.
- cpu_led  in  N_LED  LED value from the cpu core.
- sw_clean  out  N_SW  debounced switches to the cpu.
- cpu_en  out  1  cpu clock enable.
- led_out  out  N_LED  registered LED drive.
- en_count  out  16  count of cpu_en cycles.
- heartbeat  out  1  slow-tick indicator (optional feature).

Behaviour:
- Reset: on a rising fastclk edge with n_reset=0, reset all registers:
  - sw_clean=0, debounced mode=HALT, step state=0.
  - cpu_en=0, led_out=0, en_count=0, heartbeat=0.
  - tick counter=0, all debounce counters=0.
  - Reset mid-operation aborts any pending step or tick.
- Input conditioning: every raw bit (sw_raw, mode_raw, step_raw) passes through a 2-flop synchroniser, then a debouncer.
  - Debouncer output changes only after the synchronised input differs from the output for DB_CYCLES consecutive cycles.
  - Any cycle where input equals output clears that bit's counter.
  - Total latency from a raw change to the clean output is 2+DB_CYCLES cycles.
- Tick: counter counts 0..DIV-1 and wraps. tick=1 for one cycle when counter==DIV-1.
- Mode FSM: state equals the debounced mode, 00 HALT, 01 SLOW, 10 FAST, 11 STEP. Any transition is allowed and is applied the cycle after the debounced value changes.
  - HALT: cpu_en=0.
  - SLOW: cpu_en=tick, registered, so it asserts one cycle after tick. On entry to SLOW the tick counter is cleared, so the first cpu_en comes DIV+1 cycles after entry.
  - FAST: cpu_en=1 every cycle, starting the cycle after entry.
  - STEP: cpu_en=1 for exactly one cycle after each debounced rising edge of step. A held button gives one pulse only. Edges in any other mode are discarded and are not queued.
  - A step edge coinciding with a mode change out of STEP: no pulse.
- LED: led_out loads cpu_led in the cycle after a cycle with cpu_en=1; otherwise it holds. In HALT, led_out freezes.
- en_count: increments by 1 in each cycle where cpu_en=1, wrapping 0xFFFF→0x0000.

Optional Feature:
- Macro: PICOMIPS_HEARTBEAT_EN.
- Defined:
  - heartbeat toggles on every tick, in all modes including HALT.
  - led_out[N_LED-1] is driven by heartbeat instead of the cpu bit.
- Undefined:
  - heartbeat is tied 0.
  - led_out is the full registered cpu_led.

Decomposition:
- Package picomips_demo_pkg holds:
  - typedef enum logic [1:0] run_mode_t {HALT, SLOW, FAST, STEP}.
  - Function clog2-based width helper.
  - localparam EN_COUNT_W=16.
- Sub-module sync_debounce: one bit, parameter DB_CYCLES; contains the synchroniser, counter and clean output. Instantiate it via generate for N_SW+3 bits.
- Top contains the tick counter, mode FSM, step edge detector, LED register and en_count.

Test Plan (CLK_HZ=100, TICK_HZ=10 → DIV=10, DB_CYCLES=4):
- Debounce: sw_raw[0]=1 for 3 cycles then 0, then 1 held → sw_clean[0] stays 0 through the glitch, rises exactly 6 cycles after the final rise.
- SLOW mode: set mode_raw=01 from HALT → cpu_en pulses are single-cycle, exactly 10 cycles apart; en_count=3 after the third pulse.
- STEP mode: mode=11, step_raw held high 50 cycles, then released, pressed again → exactly 2 cpu_en pulses; en_count=2; button bounce shorter than 4 cycles produces no pulse.
- FAST→HALT: FAST for 20 cycles with cpu_led=0xA5 → en_count=20, led_out=0xA5; change to HALT, cpu_led=0x3C → led_out stays 0xA5, cpu_en=0.
- Wrap/reset: preload via 65535 FAST cycles → next cycle en_count=0; assert n_reset mid-run → all outputs 0 on the next edge, mode HALT.
- Heartbeat (macro defined): HALT for 40 cycles → heartbeat toggles 4 times; led_out[7]=heartbeat.
